// File: rtl/joypad_pkg.sv
// Shared types and constants for the joypad responder.
// Build option: JOYPAD_TURBO_EN adds the I_turbo port and turbo counter.
package joypad_pkg;

    localparam int JOY_WIDTH = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [3:0] COUNT_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } joy_state_t;

endpackage

// File: rtl/joypad_responder_debounce.sv
// Per-button synchronizer chain followed by a consecutive-cycle debounce filter.
// A new level is accepted after 2^P_debounce_bits disagreeing cycles in a row.
module debounce #(
    parameter int P_sync_stages   = 2,
    parameter int P_debounce_bits = 10
) (
    input  logic I_clock,
    input  logic I_reset,
    input  logic I_raw,
    output logic O_stable
);

    logic [P_sync_stages-1:0]   r_sync;
    logic [P_debounce_bits-1:0] r_count;
    logic                       r_stable;
    logic                       w_synced;

    assign w_synced = r_sync[P_sync_stages-1];
    assign O_stable = r_stable;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= I_raw;
            for (int i = 1; i < P_sync_stages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Counter full on the last disagreeing cycle means 2^N cycles have elapsed
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_count  <= '0;
            r_stable <= 1'b0;
        end else if (w_synced == r_stable) begin
            r_count <= '0;
        end else if (&r_count) begin
            r_count  <= '0;
            r_stable <= w_synced;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/joypad_responder.sv
// Console-facing joypad shift register: latch on strobe, serialise on shift clock.
// Build option: JOYPAD_TURBO_EN gates buttons A/B with a free-running turbo phase.
module joypad_responder
    import joypad_pkg::*;
#(
    parameter int P_sync_stages   = 2,
    parameter int P_debounce_bits = 10,
    parameter int P_turbo_bits    = 20
) (
    input  logic                 I_clock,
    input  logic                 I_reset,
    input  logic [JOY_WIDTH-1:0] I_buttons,
    input  logic                 I_strobe,
    input  logic                 I_shift_clock,
`ifdef JOYPAD_TURBO_EN
    input  logic [1:0]           I_turbo,
`endif
    output logic                 O_data,
    output logic                 O_done
);

    logic [JOY_WIDTH-1:0]     w_stable;
    logic [JOY_WIDTH-1:0]     w_load;
    logic [JOY_WIDTH-1:0]     w_shifted;
    logic [3:0]               w_count_inc;
    logic                     w_strobe;
    logic                     w_shclk;
    logic                     w_fall;

    logic [P_sync_stages-1:0] r_strobe_sync;
    logic [P_sync_stages-1:0] r_shclk_sync;
    logic                     r_shclk_q;

    joy_state_t               r_state;
    logic [JOY_WIDTH-1:0]     r_shift;
    logic [3:0]               r_count;
    logic                     r_data;
    logic                     r_done;

    for (genvar g = 0; g < JOY_WIDTH; g++) begin : g_btn
        debounce #(
            .P_sync_stages   (P_sync_stages),
            .P_debounce_bits (P_debounce_bits)
        ) u_debounce (
            .I_clock  (I_clock),
            .I_reset  (I_reset),
            .I_raw    (I_buttons[g]),
            .O_stable (w_stable[g])
        );
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_strobe_sync <= '0;
            r_shclk_sync  <= '0;
            r_shclk_q     <= 1'b0;
        end else begin
            r_strobe_sync[0] <= I_strobe;
            r_shclk_sync[0]  <= I_shift_clock;
            for (int i = 1; i < P_sync_stages; i++) begin
                r_strobe_sync[i] <= r_strobe_sync[i-1];
                r_shclk_sync[i]  <= r_shclk_sync[i-1];
            end
            r_shclk_q <= w_shclk;
        end
    end

    assign w_strobe = r_strobe_sync[P_sync_stages-1];
    assign w_shclk  = r_shclk_sync[P_sync_stages-1];
    assign w_fall   = r_shclk_q & ~w_shclk;

`ifdef JOYPAD_TURBO_EN
    logic [P_turbo_bits-1:0] r_turbo;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_turbo <= '0;
        end else begin
            r_turbo <= r_turbo + 1'b1;
        end
    end

    always_comb begin
        w_load = w_stable;
        if (I_turbo[0]) begin
            w_load[BTN_A] = w_stable[BTN_A] & r_turbo[P_turbo_bits-1];
        end
        if (I_turbo[1]) begin
            w_load[BTN_B] = w_stable[BTN_B] & r_turbo[P_turbo_bits-1];
        end
    end
`else
    assign w_load = w_stable;
`endif

    // Ones shift in from the top so an over-read returns "pressed"
    assign w_shifted   = {1'b1, r_shift[JOY_WIDTH-1:1]};
    assign w_count_inc = r_count + 4'd1;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_data  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_strobe) begin
            r_state <= LOAD;
            r_shift <= w_load;
            r_count <= '0;
            r_data  <= w_load[0];
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_data <= 1'b0;
                    r_done <= 1'b0;
                end
                LOAD: begin
                    r_state <= SHIFT;
                    r_data  <= r_shift[0];
                    r_done  <= 1'b0;
                end
                SHIFT: begin
                    if (w_fall) begin
                        r_shift <= w_shifted;
                        r_count <= w_count_inc;
                        if (w_count_inc == COUNT_MAX) begin
                            r_state <= DRAIN;
                            r_data  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_data <= w_shifted[0];
                        end
                    end
                end
                DRAIN: begin
                    r_data <= 1'b1;
                    r_done <= 1'b1;
                end
            endcase
        end
    end

    assign O_data = r_data;
    assign O_done = r_done;

endmodule
